// File: rtl/count_seq_checker_pkg.sv
// rtl/count_seq_checker_pkg.sv - shared types, widths and saturating-increment helper
package count_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } chk_state_t;

    // Holds at the all-ones value of a width-bit counter; width must be below 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/count_seq_checker_if.sv
// rtl/count_seq_checker_if.sv - count stream and checker status bundle
interface count_seq_checker_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     count_in;
    logic                 sample_en;
    logic                 locked;
    logic                 mismatch;
    logic                 restart;
    logic [ERR_CNT_W-1:0] err_count;
    logic [ERR_CNT_W-1:0] wrap_count;
    logic [WIDTH-1:0]     last_bad;

    modport master (
        output count_in, sample_en,
        input  locked, mismatch, restart, err_count, wrap_count, last_bad
    );

    modport slave (
        input  count_in, sample_en,
        output locked, mismatch, restart, err_count, wrap_count, last_bad
    );
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// rtl/count_seq_checker_sat_counter.sv - saturating event counter with sync reset
module sat_counter
    import count_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [31:0]      next_val;

    always_comb begin
        next_val = sat_inc(32'(count_q), WIDTH);
        count_d  = count_q;
        if (inc) begin
            count_d = next_val[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - locks onto a +1 count stream and reports glitches, restarts and wraps
module count_seq_checker
    import count_pkg::*;
#(
    parameter int WIDTH     = COUNT_W,
    parameter int LOCK_LEN  = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    count_seq_checker_if.slave  bus
);

    localparam logic [0:0] ST_ACQUIRE = 1'(ACQUIRE);
    localparam logic [0:0] ST_LOCKED  = 1'(LOCKED);
    localparam logic [3:0] LOCK_RUN   = 4'(LOCK_LEN);

    logic [0:0]       state_q,    state_d;
    logic [WIDTH-1:0] prev_q,     prev_d;
    logic [3:0]       run_len_q,  run_len_d;
    logic [1:0]       miss_run_q, miss_run_d;
    logic             mismatch_q, mismatch_d;
    logic             restart_q,  restart_d;
    logic [WIDTH-1:0] last_bad_q, last_bad_d;
    logic             err_inc;
    logic             wrap_inc;
    logic [WIDTH-1:0] exp_val;

    assign exp_val = prev_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        run_len_d  = run_len_q;
        miss_run_d = miss_run_q;
        mismatch_d = 1'b0;
        restart_d  = 1'b0;
        last_bad_d = last_bad_q;
        err_inc    = 1'b0;
        wrap_inc   = 1'b0;

        if (bus.sample_en) begin
            if (state_q == ST_ACQUIRE) begin
                prev_d = bus.count_in;
                if (run_len_q == 4'd0 || bus.count_in != exp_val) begin
                    run_len_d = 4'd1;
                end else begin
                    run_len_d = run_len_q + 4'd1;
                    if (run_len_q + 4'd1 == LOCK_RUN) begin
                        state_d    = ST_LOCKED;
                        miss_run_d = 2'd0;
                    end
                end
            end else begin
                if (bus.count_in == exp_val) begin
                    prev_d     = bus.count_in;
                    miss_run_d = 2'd0;
                    wrap_inc   = (prev_q == '1);
                end else if (bus.count_in == '0) begin
                    // exp_val is non-zero here, so a zero is a counter restart, not a glitch
                    restart_d  = 1'b1;
                    prev_d     = '0;
                    miss_run_d = 2'd0;
                end else begin
                    mismatch_d = 1'b1;
                    err_inc    = 1'b1;
                    last_bad_d = bus.count_in;
                    prev_d     = bus.count_in;
                    miss_run_d = miss_run_q + 2'd1;
                    if (miss_run_q == 2'd1) begin
                        state_d    = ST_ACQUIRE;
                        run_len_d  = 4'd1;
                        miss_run_d = 2'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACQUIRE;
            prev_q     <= '0;
            run_len_q  <= 4'd0;
            miss_run_q <= 2'd0;
            mismatch_q <= 1'b0;
            restart_q  <= 1'b0;
            last_bad_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_len_q  <= run_len_d;
            miss_run_q <= miss_run_d;
            mismatch_q <= mismatch_d;
            restart_q  <= restart_d;
            last_bad_q <= last_bad_d;
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (bus.err_count)
    );

    sat_counter #(.WIDTH(ERR_CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc),
        .count (bus.wrap_count)
    );

    assign bus.locked   = (state_q == ST_LOCKED);
    assign bus.mismatch = mismatch_q;
    assign bus.restart  = restart_q;
    assign bus.last_bad = last_bad_q;

endmodule
